db_sense_detect: RTL



---
 rtl/db_sense_detect.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/db_sense_detect.sv
// Daughterboard SENSE pin sampler: periodic release/settle/sample, debounced
// presence flag with insert/remove pulses, and arbitration of host drive requests.
module db_sense_detect #(
    parameter int unsigned PERIOD   = 16,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sense_i,
    output logic sense_o,
    output logic sense_oe,
    input  logic drive_req_i,
    input  logic drive_val_i,
    output logic drive_ack_o,
    output logic present_o,
    output logic valid_o,
    output logic insert_o,
    output logic remove_o
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [DEB_W-1:0] DEB_MAX     = DEB_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DRIVE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              sync1_q, sync2_q;
    logic              cand_q, cand_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic              present_q, present_d;
    logic              valid_q, valid_d;
    logic              insert_q, insert_d;
    logic              remove_q, remove_d;
    logic              oe_q, oe_d;
    logic              so_q, so_d;
    logic              raw;

    // Pin is pulled low by a fitted board, so presence is the inverted level.
    assign raw = ~sync2_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        present_d = present_q;
        valid_d   = valid_q;
        insert_d  = 1'b0;
        remove_d  = 1'b0;
        oe_d      = 1'b0;
        so_d      = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (drive_req_i) begin
                    state_d = ST_DRIVE;
                    timer_d = '0;
                    oe_d    = 1'b1;
                    so_d    = drive_val_i;
                end else if (timer_q == WAIT_LAST) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (drive_req_i) begin
                    state_d = ST_DRIVE;
                    timer_d = '0;
                    oe_d    = 1'b1;
                    so_d    = drive_val_i;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (raw == cand_q) begin
                    cnt_d = (cnt_q >= DEB_MAX) ? DEB_MAX : cnt_q + DEB_W'(1);
                end else begin
                    cand_d = raw;
                    cnt_d  = DEB_W'(1);
                end
                // Qualification uses the post-update count and candidate.
                if ((cnt_d == DEB_MAX) && (!valid_q || (cand_d != present_q))) begin
                    present_d = cand_d;
                    valid_d   = 1'b1;
                    if (valid_q) begin
                        insert_d = cand_d;
                        remove_d = ~cand_d;
                    end
                end
                timer_d = '0;
                if (drive_req_i) begin
                    state_d = ST_DRIVE;
                    oe_d    = 1'b1;
                    so_d    = drive_val_i;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRIVE: begin
                timer_d = '0;
                if (drive_req_i) begin
                    oe_d = 1'b1;
                    so_d = drive_val_i;
                end else begin
                    // Full settle after release so our own drive is never sampled.
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_WAIT;
            timer_q   <= '0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cand_q    <= 1'b0;
            cnt_q     <= '0;
            present_q <= 1'b0;
            valid_q   <= 1'b0;
            insert_q  <= 1'b0;
            remove_q  <= 1'b0;
            oe_q      <= 1'b0;
            so_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sync1_q   <= sense_i;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            present_q <= present_d;
            valid_q   <= valid_d;
            insert_q  <= insert_d;
            remove_q  <= remove_d;
            oe_q      <= oe_d;
            so_q      <= so_d;
        end
    end

    assign sense_o     = so_q;
    assign sense_oe    = oe_q;
    assign drive_ack_o = oe_q;
    assign present_o   = present_q;
    assign valid_o     = valid_q;
    assign insert_o    = insert_q;
    assign remove_o    = remove_q;

endmodule
